// File: rtl/car_motion_ctrl.sv
// rtl/car_motion_ctrl.sv - elevator car motion controller with floor and door timers
//
// Purpose: moves the car between floors 1..5 toward dest, stopping at dest, at any
//   intermediate floor with a pending request, at the travel limits, or at the next
//   floor when dest has moved behind the car. Door dwell and floor travel are timed
//   by a shared cycle counter.
// Ports:
//   clk          system clock, rising edge
//   resetn       synchronous active-low reset
//   enable       1 = run, 0 = freeze all state (arrive forced low)
//   dest         target floor 1..5; 0,6,7 = no target
//   req_pending  bit i = request latched for floor i+1
//   state        0 IDLE, 1 DOOR, 2 UP, 3 DOWN
//   location     current floor 1..5
//   door_open    high while state is DOOR
//   arrive       one-cycle pulse on the edge location changes
module car_motion_ctrl #(
  parameter int FLOOR_TICKS = 50_000_000,
  parameter int DOOR_TICKS  = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [2:0] dest,
  input  logic [4:0] req_pending,
  output logic [1:0] state,
  output logic [2:0] location,
  output logic       door_open,
  output logic       arrive
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DOOR = 2'd1,
    S_UP   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);

  state_t           st;
  logic [CNT_W-1:0] timer;

  logic       going_up;
  logic       dest_ok;
  logic [2:0] nxt_loc;
  logic       req_hit;
  logic       stop_here;

  assign state = st;

  // Floor the car reaches at the next arrival, clamped so it never leaves 1..5,
  // and whether it must stop there.
  always_comb begin
    going_up = (st == S_UP);
    dest_ok  = (dest >= 3'd1) && (dest <= 3'd5);
    if (going_up)
      nxt_loc = (location >= 3'd5) ? 3'd5 : location + 3'd1;
    else
      nxt_loc = (location <= 3'd1) ? 3'd1 : location - 3'd1;

    req_hit = 1'b0;
    case (nxt_loc)
      3'd1: req_hit = req_pending[0];
      3'd2: req_hit = req_pending[1];
      3'd3: req_hit = req_pending[2];
      3'd4: req_hit = req_pending[3];
      3'd5: req_hit = req_pending[4];
      default: req_hit = 1'b0;
    endcase

    // Reaching dest or finding it behind the car both stop here; IDLE then
    // picks the new direction.
    stop_here = req_hit
             || ( going_up && (nxt_loc == 3'd5))
             || (!going_up && (nxt_loc == 3'd1))
             || (dest_ok &&  going_up && (dest <= nxt_loc))
             || (dest_ok && !going_up && (dest >= nxt_loc));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st        <= S_IDLE;
      location  <= 3'd1;
      timer     <= '0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
    end else if (!enable) begin
      arrive <= 1'b0;
    end else begin
      arrive <= 1'b0;
      case (st)
        S_IDLE: begin
          timer <= '0;
          if (dest_ok && (dest > location))
            st <= S_UP;
          else if (dest_ok && (dest < location))
            st <= S_DOWN;
        end

        S_UP, S_DOWN: begin
          if (timer == FLOOR_LAST) begin
            timer    <= '0;
            location <= nxt_loc;
            arrive   <= 1'b1;
            if (stop_here) begin
              st        <= S_DOOR;
              door_open <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DOOR: begin
          if (timer == DOOR_LAST) begin
            timer     <= '0;
            st        <= S_IDLE;
            door_open <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          st        <= S_IDLE;
          timer     <= '0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb/tb_car_motion_ctrl.sv - directed self-checking bench for car_motion_ctrl
module tb_car_motion_ctrl;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [2:0] dest;
  logic [4:0] req_pending;
  logic [1:0] state;
  logic [2:0] location;
  logic       door_open;
  logic       arrive;

  int n_checks;
  int n_fail;

  car_motion_ctrl #(
    .FLOOR_TICKS(4),
    .DOOR_TICKS (3),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .dest       (dest),
    .req_pending(req_pending),
    .state      (state),
    .location   (location),
    .door_open  (door_open),
    .arrive     (arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then sampled 1 ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; dest = 3'd0; req_pending = 5'b0;
    tick(1);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (location !== 3'd1) begin n_fail++; $display("FAIL reset_loc got=%0d exp=1", location); end
    n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL reset_door got=%0b exp=0", door_open); end
    n_checks++; if (arrive !== 1'b0) begin n_fail++; $display("FAIL reset_arrive got=%0b exp=0", arrive); end
    resetn = 1'b1;
  endtask

  task automatic test_up_trip();
    dest = 3'd3;
    tick(1);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL up_start got=%0d exp=2", state); end
    tick(3);
    n_checks++; if (location !== 3'd1 || arrive !== 1'b0) begin n_fail++; $display("FAIL up_pre_arrive loc=%0d arr=%0b exp loc=1 arr=0", location, arrive); end
    tick(1);
    n_checks++; if (location !== 3'd2 || arrive !== 1'b1 || state !== 2'd2) begin n_fail++; $display("FAIL up_loc2 loc=%0d arr=%0b st=%0d exp 2/1/2", location, arrive, state); end
    tick(1);
    n_checks++; if (arrive !== 1'b0) begin n_fail++; $display("FAIL up_arrive_pulse got=%0b exp=0", arrive); end
    tick(3);
    n_checks++; if (location !== 3'd3 || state !== 2'd1 || door_open !== 1'b1) begin n_fail++; $display("FAIL up_loc3 loc=%0d st=%0d door=%0b exp 3/1/1", location, state, door_open); end
    tick(2);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL up_dwell got=%0d exp=1", state); end
    tick(1);
    n_checks++; if (state !== 2'd0 || door_open !== 1'b0) begin n_fail++; $display("FAIL up_close st=%0d door=%0b exp 0/0", state, door_open); end
  endtask

  task automatic test_intermediate();
    resetn = 1'b0; tick(1); resetn = 1'b1;
    dest = 3'd5; req_pending = 5'b00010;
    tick(5);
    n_checks++; if (location !== 3'd2 || state !== 2'd1) begin n_fail++; $display("FAIL mid_stop loc=%0d st=%0d exp 2/1", location, state); end
    req_pending = 5'b0;
    tick(3);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL mid_close got=%0d exp=0", state); end
    tick(1);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL mid_resume got=%0d exp=2", state); end
    tick(4);
    n_checks++; if (location !== 3'd3 || state !== 2'd2 || arrive !== 1'b1) begin n_fail++; $display("FAIL mid_pass3 loc=%0d st=%0d arr=%0b exp 3/2/1", location, state, arrive); end
    tick(8);
    n_checks++; if (location !== 3'd5 || state !== 2'd1) begin n_fail++; $display("FAIL mid_top loc=%0d st=%0d exp 5/1", location, state); end
    tick(3);
  endtask

  task automatic test_down_invalid();
    dest = 3'd4;
    tick(5);
    n_checks++; if (location !== 3'd4 || state !== 2'd1) begin n_fail++; $display("FAIL dn_to4 loc=%0d st=%0d exp 4/1", location, state); end
    tick(3);
    dest = 3'd0;
    tick(2);
    n_checks++; if (state !== 2'd0 || location !== 3'd4) begin n_fail++; $display("FAIL dn_invalid st=%0d loc=%0d exp 0/4", state, location); end
    dest = 3'd7;
    tick(1);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL dn_invalid7 got=%0d exp=0", state); end
    dest = 3'd1;
    tick(1);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL dn_start got=%0d exp=3", state); end
    tick(4);
    n_checks++; if (location !== 3'd3 || arrive !== 1'b1 || state !== 2'd3) begin n_fail++; $display("FAIL dn_loc3 loc=%0d arr=%0b st=%0d exp 3/1/3", location, arrive, state); end
    tick(4);
    n_checks++; if (location !== 3'd2 || state !== 2'd3) begin n_fail++; $display("FAIL dn_loc2 loc=%0d st=%0d exp 2/3", location, state); end
    tick(4);
    n_checks++; if (location !== 3'd1 || state !== 2'd1 || door_open !== 1'b1) begin n_fail++; $display("FAIL dn_loc1 loc=%0d st=%0d door=%0b exp 1/1/1", location, state, door_open); end
    tick(3);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL dn_close got=%0d exp=0", state); end
  endtask

  task automatic test_freeze();
    dest = 3'd2;
    tick(1);
    tick(2);
    enable = 1'b0;
    tick(10);
    n_checks++; if (location !== 3'd1 || state !== 2'd2 || arrive !== 1'b0) begin n_fail++; $display("FAIL frz_hold loc=%0d st=%0d arr=%0b exp 1/2/0", location, state, arrive); end
    enable = 1'b1;
    tick(1);
    n_checks++; if (location !== 3'd1 || arrive !== 1'b0) begin n_fail++; $display("FAIL frz_early loc=%0d arr=%0b exp 1/0", location, arrive); end
    tick(1);
    n_checks++; if (location !== 3'd2 || arrive !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL frz_arrive loc=%0d arr=%0b st=%0d exp 2/1/1", location, arrive, state); end
    enable = 1'b0;
    tick(5);
    n_checks++; if (arrive !== 1'b0 || state !== 2'd1 || door_open !== 1'b1) begin n_fail++; $display("FAIL frz_door arr=%0b st=%0d door=%0b exp 0/1/1", arrive, state, door_open); end
    enable = 1'b1;
    tick(3);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL frz_close got=%0d exp=0", state); end
  endtask

  task automatic test_reverse();
    dest = 3'd5;
    tick(5);
    n_checks++; if (location !== 3'd3 || state !== 2'd2) begin n_fail++; $display("FAIL rev_loc3 loc=%0d st=%0d exp 3/2", location, state); end
    dest = 3'd1;
    tick(4);
    n_checks++; if (location !== 3'd4 || state !== 2'd1) begin n_fail++; $display("FAIL rev_stop loc=%0d st=%0d exp 4/1", location, state); end
    tick(4);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL rev_down got=%0d exp=3", state); end
  endtask

  task automatic test_mid_reset();
    resetn = 1'b0; tick(1); resetn = 1'b1;
    dest = 3'd5;
    tick(9);
    n_checks++; if (location !== 3'd3 || state !== 2'd2) begin n_fail++; $display("FAIL mrst_pre loc=%0d st=%0d exp 3/2", location, state); end
    tick(1);
    resetn = 1'b0;
    tick(1);
    n_checks++; if (state !== 2'd0 || location !== 3'd1 || arrive !== 1'b0 || door_open !== 1'b0) begin n_fail++; $display("FAIL mrst st=%0d loc=%0d arr=%0b door=%0b exp 0/1/0/0", state, location, arrive, door_open); end
    dest = 3'd0;
    resetn = 1'b1;
    tick(2);
    n_checks++; if (state !== 2'd0 || location !== 3'd1) begin n_fail++; $display("FAIL mrst_after st=%0d loc=%0d exp 0/1", state, location); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    resetn = 1'b0; enable = 1'b1; dest = 3'd0; req_pending = 5'b0;
    #2;
    test_reset();
    test_up_trip();
    test_intermediate();
    test_down_invalid();
    test_freeze();
    test_reverse();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
